// File: rtl/md5_host_pkg.sv
// rtl/md5_host_pkg.sv - shared command words, match header and TX state type for the host link
package md5_host_pkg;

  localparam logic [31:0] CMD_GET_COUNT_LOW  = 32'h52303000;
  localparam logic [31:0] CMD_GET_COUNT_HIGH = 32'h52303001;
  localparam logic [31:0] CMD_LOAD_HASH      = 32'h48000000;
  localparam logic [31:0] CMD_START          = 32'h53000000;
  localparam logic [31:0] CMD_STOP           = 32'h50000000;

  localparam logic [31:0] MATCH_MAGIC = 32'h4D443521;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND_REPLY,
    TX_SEND_MATCH
  } tx_state_t;

  function automatic logic is_count_query(input logic [31:0] w);
    return (w == CMD_GET_COUNT_LOW) || (w == CMD_GET_COUNT_HIGH);
  endfunction

endpackage

// File: rtl/md5_word_assembler.sv
// rtl/md5_word_assembler.sv - little-endian byte to word assembly with partial-word timeout
module md5_word_assembler
  import md5_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        word_valid,
  output logic [31:0] word_out
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    idx;
  logic [23:0]   held;
  logic [TW-1:0] idle_cnt;
  logic          expire;

  assign expire = (idx != 2'd0) && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= 2'd0;
      held       <= '0;
      idle_cnt   <= '0;
      word_valid <= 1'b0;
      word_out   <= '0;
    end else begin
      word_valid <= 1'b0;
      if (rx_valid || (idx == 2'd0) || expire)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;

      // A byte landing on the expiry cycle starts a fresh word
      if (expire) begin
        if (rx_valid) begin
          held[7:0] <= rx_byte;
          idx       <= 2'd1;
        end else begin
          idx <= 2'd0;
        end
      end else if (rx_valid) begin
        case (idx)
          2'd0: held[7:0]   <= rx_byte;
          2'd1: held[15:8]  <= rx_byte;
          2'd2: held[23:16] <= rx_byte;
          default: begin
            word_out   <= {rx_byte, held};
            word_valid <= 1'b1;
          end
        endcase
        idx <= idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/md5_host_link.sv
// rtl/md5_host_link.sv - host byte link: RX word strobes, count replies and match frames on TX
module md5_host_link #(
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter int          REPLY_DELAY    = 4,
  parameter logic [31:0] MATCH_MAGIC    = md5_host_pkg::MATCH_MAGIC
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx_valid,
  input  logic [7:0]   rx_byte,
  input  logic         tx_ready,
  output logic         tx_valid,
  output logic [7:0]   tx_byte,
  output logic         word_valid,
  output logic [31:0]  word_out,
  input  logic [31:0]  reply_word,
  input  logic         has_matched,
  input  logic [127:0] text
);
  import md5_host_pkg::*;

  localparam int DW = $clog2(REPLY_DELAY + 1);

  tx_state_t      state, state_d;
  logic           reply_pend, match_pend, delay_on, hm_q;
  logic [DW-1:0]  delay_cnt;
  logic [31:0]    reply_q;
  logic [159:0]   frame;
  logic [4:0]     byte_cnt;
  logic           query_hit, reply_fire;
  logic           load_reply, load_match, accept, last_byte;

  md5_word_assembler #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_asm (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .word_valid (word_valid),
    .word_out   (word_out)
  );

  assign query_hit  = word_valid && is_count_query(word_out);
  assign reply_fire = delay_on && !query_hit && (delay_cnt == DW'(REPLY_DELAY - 1));

  // A newer query restarts the delay; the older one is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      delay_on   <= 1'b0;
      delay_cnt  <= '0;
      reply_q    <= '0;
      reply_pend <= 1'b0;
      match_pend <= 1'b0;
      hm_q       <= 1'b0;
    end else begin
      hm_q <= has_matched;
      if (query_hit) begin
        delay_on  <= 1'b1;
        delay_cnt <= DW'(1);
      end else if (reply_fire) begin
        delay_on <= 1'b0;
        reply_q  <= reply_word;
      end else if (delay_on) begin
        delay_cnt <= delay_cnt + 1'b1;
      end

      if (load_reply) reply_pend <= 1'b0;
      if (reply_fire) reply_pend <= 1'b1;
      if (load_match) match_pend <= 1'b0;
      if (has_matched && !hm_q) match_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= TX_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d    = state;
    load_reply = 1'b0;
    load_match = 1'b0;
    accept     = (state != TX_IDLE) && tx_ready;
    last_byte  = accept && (byte_cnt == ((state == TX_SEND_REPLY) ? 5'd3 : 5'd19));
    case (state)
      TX_IDLE: begin
        if (reply_pend) begin
          state_d    = TX_SEND_REPLY;
          load_reply = 1'b1;
        end else if (match_pend) begin
          state_d    = TX_SEND_MATCH;
          load_match = 1'b1;
        end
      end
      default: if (last_byte) state_d = TX_IDLE;
    endcase
  end

  // Frame is copied at start so requests landing mid-frame cannot disturb it
  always_ff @(posedge clk) begin
    if (reset) begin
      frame    <= '0;
      byte_cnt <= '0;
    end else if (load_reply) begin
      frame    <= {128'd0, reply_q};
      byte_cnt <= '0;
    end else if (load_match) begin
      frame    <= {text, MATCH_MAGIC};
      byte_cnt <= '0;
    end else if (accept) begin
      frame    <= {8'd0, frame[159:8]};
      byte_cnt <= byte_cnt + 5'd1;
    end
  end

  assign tx_valid = (state != TX_IDLE);
  assign tx_byte  = frame[7:0];

endmodule

// File: tb/tb_md5_host_link.sv
// tb/tb_md5_host_link.sv - randomized and directed bench with a byte-stream reference model
module tb_md5_host_link;
  localparam int TO = 40;
  localparam int RD = 4;
  localparam logic [31:0] MAGIC = 32'h4D443521;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_byte = 8'd0;
  logic         tx_ready = 1'b0;
  logic         tx_valid;
  logic [7:0]   tx_byte;
  logic         word_valid;
  logic [31:0]  word_out;
  logic [31:0]  reply_word = 32'd0;
  logic         has_matched = 1'b0;
  logic [127:0] text = 128'd0;

  md5_host_link #(.TIMEOUT_CYCLES(TO), .REPLY_DELAY(RD)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_byte(tx_byte),
    .word_valid(word_valid), .word_out(word_out), .reply_word(reply_word),
    .has_matched(has_matched), .text(text)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: expected strobe/word, pending requests, expected TX byte stream
  logic        exp_wv = 1'b0;
  logic [31:0] exp_word = 32'd0;
  logic [7:0]  pb [4];
  int          pc = 0;
  int          lb = 0;
  bit          rep_pend = 0;
  logic [31:0] rep_val = 32'd0;
  int          rep_deadline = -1;
  bit          mat_pend = 0;
  bit          prev_hm = 0;
  logic [7:0]  txq [$];
  bit          sending = 0;
  logic [31:0] magic_v = MAGIC;

  logic [7:0]  seen_tx [$];
  logic [31:0] seen_words [$];

  always @(negedge clk) begin
    bit launch;
    cyc++;
    chk("word_valid", 32'(word_valid), 32'(exp_wv));
    chk("word_out", word_out, exp_word);
    chk("tx_valid", 32'(tx_valid), 32'(sending));
    if (sending) chk("tx_byte", 32'(tx_byte), 32'(txq[0]));
    if (word_valid) seen_words.push_back(word_out);
    if (tx_valid && tx_ready) seen_tx.push_back(tx_byte);

    if (reset) begin
      exp_wv = 0; exp_word = 0; pc = 0; rep_pend = 0; rep_deadline = -1;
      mat_pend = 0; prev_hm = 0; txq.delete(); sending = 0;
    end else begin
      launch = 0;
      if (!sending) begin
        if (rep_pend) begin
          for (int i = 0; i < 4; i++) txq.push_back(rep_val[8*i +: 8]);
          rep_pend = 0; launch = 1;
        end else if (mat_pend) begin
          for (int i = 0; i < 4; i++) txq.push_back(magic_v[8*i +: 8]);
          for (int i = 0; i < 16; i++) txq.push_back(text[8*i +: 8]);
          mat_pend = 0; launch = 1;
        end
      end
      if (sending && tx_ready) begin
        void'(txq.pop_front());
        if (txq.size() == 0) sending = 0;
      end
      if (launch) sending = 1;

      if (exp_wv && (exp_word == 32'h52303000 || exp_word == 32'h52303001))
        rep_deadline = cyc + RD - 1;
      if (rep_deadline == cyc) begin
        rep_val = reply_word; rep_pend = 1; rep_deadline = -1;
      end
      if (has_matched && !prev_hm) mat_pend = 1;
      prev_hm = has_matched;

      exp_wv = 0;
      if (rx_valid) begin
        if (pc > 0 && (cyc - lb) >= TO) pc = 0;
        pb[pc] = rx_byte; pc++; lb = cyc;
        if (pc == 4) begin
          exp_wv = 1; exp_word = {pb[3], pb[2], pb[1], pb[0]}; pc = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_byte = b; tick(); rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input string name, input int n, input int budget);
    int k = 0;
    while (seen_tx.size() < n && k < budget) begin tick(); k++; end
    chk(name, seen_tx.size(), n);
  endtask

  function automatic logic [31:0] sw(input int i);
    return (seen_words.size() > i) ? seen_words[i] : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] st(input int i);
    return (seen_tx.size() > i) ? 32'(seen_tx[i]) : 32'hxxxxxxxx;
  endfunction

  logic [7:0] feed [$];
  int base, hold, k;
  logic [31:0] w;

  initial begin
    idle(3);
    chk("rst tx_valid", 32'(tx_valid), 0);
    chk("rst tx_byte", 32'(tx_byte), 0);
    chk("rst word_out", word_out, 0);
    reset = 1'b0;
    tx_ready = 1'b1;
    idle(2);

    seen_words.delete(); seen_tx.delete();
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h30); send_byte(8'h52);
    idle(12);
    chk("plain strobes", seen_words.size(), 1);
    chk("plain word", sw(0), 32'h52301000);
    chk("plain no tx", seen_tx.size(), 0);

    reply_word = 32'hDEADBEEF;
    send_byte(8'h01); send_byte(8'h30); send_byte(8'h30); send_byte(8'h52);
    wait_tx("reply len", 4, 40);
    idle(3);
    chk("reply b0", st(0), 32'hEF);
    chk("reply b1", st(1), 32'hBE);
    chk("reply b2", st(2), 32'hAD);
    chk("reply b3", st(3), 32'hDE);
    chk("reply end", 32'(tx_valid), 0);
    chk("reply only", seen_tx.size(), 4);

    seen_words.delete();
    send_byte(8'hAA); send_byte(8'hBB); idle(TO);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h30); send_byte(8'h52);
    idle(2);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); idle(TO - 2); send_byte(8'hDD);
    idle(2);
    send_byte(8'hAA); idle(TO - 1);
    send_byte(8'hDD); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    idle(2);
    chk("timeout strobes", seen_words.size(), 3);
    chk("timeout word", sw(0), 32'h52300000);
    chk("just-in-time word", sw(1), 32'hDDCCBBAA);
    chk("expiry-cycle word", sw(2), 32'h030201DD);

    seen_tx.delete();
    text = 128'h706f6e6d6c6b6a696867666564636261;
    has_matched = 1'b1;
    k = 0;
    while (seen_tx.size() < 20 && k < 200) begin tx_ready = ~tx_ready; tick(); k++; end
    chk("match len", seen_tx.size(), 20);
    tx_ready = 1'b1;
    idle(60);
    chk("match b0", st(0), 32'h21);
    chk("match b1", st(1), 32'h35);
    chk("match b2", st(2), 32'h44);
    chk("match b3", st(3), 32'h4D);
    chk("match b4", st(4), 32'h61);
    chk("match b7", st(7), 32'h64);
    chk("match b19", st(19), 32'h70);
    chk("match no repeat", seen_tx.size(), 20);
    has_matched = 1'b0;
    idle(2);

    seen_tx.delete();
    reply_word = 32'h11223344;
    send_byte(8'h00); send_byte(8'h30); send_byte(8'h30); send_byte(8'h52);
    idle(3);
    has_matched = 1'b1;
    wait_tx("both len", 24, 80);
    chk("both b0", st(0), 32'h44);
    chk("both b3", st(3), 32'h11);
    chk("both b4", st(4), 32'h21);
    chk("both b8", st(8), 32'h61);
    has_matched = 1'b0;
    idle(3);

    base = seen_tx.size();
    has_matched = 1'b1;
    wait_tx("pre-reset bytes", base + 5, 40);
    reset = 1'b1; tx_ready = 1'b0; has_matched = 1'b0;
    tick();
    chk("reset abort", 32'(tx_valid), 0);
    tick();
    reset = 1'b0; tx_ready = 1'b1;
    idle(30);
    chk("no resume", seen_tx.size(), base + 5);
    has_matched = 1'b1;
    wait_tx("post-reset frame", base + 25, 60);
    chk("post-reset b0", st(base + 5), 32'h21);
    has_matched = 1'b0;
    idle(3);

    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      tx_ready = ($urandom_range(3) != 0);
      reply_word = $urandom;
      if ($urandom_range(7) == 0) text = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(149) == 0) has_matched = ~has_matched;
      rx_valid = 1'b0;
      if (hold > 0) hold--;
      else if ($urandom_range(300) == 0) hold = TO - 2 + $urandom_range(4);
      else if ($urandom_range(2) == 0) begin
        if (feed.size() == 0) begin
          w = ($urandom_range(1) == 0) ? (32'h52303000 | 32'($urandom_range(1))) : $urandom;
          for (int i = 0; i < 4; i++) feed.push_back(w[8*i +: 8]);
        end
        rx_valid = 1'b1;
        rx_byte = feed.pop_front();
      end
      tick();
    end
    rx_valid = 1'b0; has_matched = 1'b0; tx_ready = 1'b1;
    k = 0;
    while ((sending || rep_pend || mat_pend || rep_deadline >= 0) && k < 500) begin tick(); k++; end
    chk("drain", 32'(sending || rep_pend || mat_pend || rep_deadline >= 0), 0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
